// File: rtl/upper_pc_table.sv
// Shared upper-PC compression table for the BTB/RAS predictors.
// Encode maps an upper PC to a 2-bit index; decode expands it back.
module upper_pc_table #(
    parameter int UPPER_PC_TABLE_ENTRIES     = 4,
    parameter int LOG_UPPER_PC_TABLE_ENTRIES = 2,
    parameter int UPPER_PC_WIDTH             = 18
) (
    input  logic                                  CLK,
    input  logic                                  RST,
    input  logic                                  read_valid,
    input  logic [LOG_UPPER_PC_TABLE_ENTRIES-1:0] read_index,
    output logic [UPPER_PC_WIDTH-1:0]             read_upper_PC,
    input  logic                                  update0_valid,
    input  logic [UPPER_PC_WIDTH-1:0]             update0_upper_PC,
    output logic [LOG_UPPER_PC_TABLE_ENTRIES-1:0] update1_upper_PC_index
);

    localparam int N  = UPPER_PC_TABLE_ENTRIES;
    localparam int IW = LOG_UPPER_PC_TABLE_ENTRIES;
    localparam int W  = UPPER_PC_WIDTH;

    logic [W-1:0]  entry_q [N];
    logic [N-1:0]  valid_q;
    logic [2:0]    plru_q;
    logic [2:0]    plru_d;

    logic [N-1:0]  hit;
    logic          miss;
    logic          hit_found;
    logic          free_found;
    logic [IW-1:0] hit_idx;
    logic [IW-1:0] free_idx;
    logic [IW-1:0] victim;
    logic [IW-1:0] upd_idx;

    function automatic logic [2:0] touch(input logic [2:0] p,
                                         input logic [1:0] e);
        logic [2:0] r;
        r    = p;
        r[0] = ~e[1];
        if (!e[1]) r[1] = ~e[0];
        else       r[2] = ~e[0];
        return r;
    endfunction

    always_comb begin
        hit        = '0;
        hit_found  = 1'b0;
        free_found = 1'b0;
        hit_idx    = '0;
        free_idx   = '0;
        for (int i = 0; i < N; i++) begin
            hit[i] = valid_q[i] && (entry_q[i] == update0_upper_PC);
        end
        // Lowest index wins for both the hit and the free-slot search
        for (int i = 0; i < N; i++) begin
            if (!hit_found && hit[i]) begin
                hit_idx   = IW'(i);
                hit_found = 1'b1;
            end
            if (!free_found && !valid_q[i]) begin
                free_idx   = IW'(i);
                free_found = 1'b1;
            end
        end
        miss = ~hit_found;
        victim = plru_q[0] ? {1'b1, plru_q[2]} : {1'b0, plru_q[1]};
        if (hit_found)       upd_idx = hit_idx;
        else if (free_found) upd_idx = free_idx;
        else                 upd_idx = victim;
    end

    // Update touch is applied last so its bits override the read touch
    always_comb begin
        plru_d = plru_q;
        if (read_valid)    plru_d = touch(plru_d, read_index);
        if (update0_valid) plru_d = touch(plru_d, upd_idx);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < N; i++) begin
                entry_q[i] <= '0;
            end
            valid_q                <= '0;
            plru_q                 <= '0;
            read_upper_PC          <= '0;
            update1_upper_PC_index <= '0;
        end else begin
            plru_q <= plru_d;
            if (read_valid) begin
                read_upper_PC <= entry_q[read_index];
            end
            if (update0_valid) begin
                update1_upper_PC_index <= upd_idx;
                if (miss) begin
                    entry_q[upd_idx] <= update0_upper_PC;
                    valid_q[upd_idx] <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_upper_pc_table.sv
// Randomized and directed checks of upper_pc_table against a
// table-level reference model.
module tb_upper_pc_table;

    logic        CLK = 1'b0;
    logic        RST;
    logic        read_valid;
    logic [1:0]  read_index;
    logic [17:0] read_upper_PC;
    logic        update0_valid;
    logic [17:0] update0_upper_PC;
    logic [1:0]  update1_upper_PC_index;

    upper_pc_table dut (
        .CLK                    (CLK),
        .RST                    (RST),
        .read_valid             (read_valid),
        .read_index             (read_index),
        .read_upper_PC          (read_upper_PC),
        .update0_valid          (update0_valid),
        .update0_upper_PC       (update0_upper_PC),
        .update1_upper_PC_index (update1_upper_PC_index)
    );

    always #5 CLK = ~CLK;

    int n_chk  = 0;
    int n_pass = 0;

    logic [17:0] m_ent [4];
    bit          m_val [4];
    logic [2:0]  m_plru;
    logic [17:0] m_rd;
    logic [1:0]  m_idx;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic void m_reset();
        for (int i = 0; i < 4; i++) begin
            m_ent[i] = '0;
            m_val[i] = 1'b0;
        end
        m_plru = '0;
        m_rd   = '0;
        m_idx  = '0;
    endfunction

    function automatic void m_touch(input logic [1:0] e);
        m_plru[0] = ~e[1];
        if (e[1] == 1'b0) m_plru[1] = ~e[0];
        else              m_plru[2] = ~e[0];
    endfunction

    function automatic void m_step(input bit rv, input logic [1:0] ri,
                                   input bit uv, input logic [17:0] u);
        int sel;
        logic [2:0] p0;
        p0 = m_plru;
        if (rv) begin
            m_rd = m_ent[ri];
            m_touch(ri);
        end
        if (uv) begin
            sel = -1;
            for (int i = 3; i >= 0; i--)
                if (m_val[i] && m_ent[i] == u) sel = i;
            if (sel < 0) begin
                for (int i = 3; i >= 0; i--)
                    if (!m_val[i]) sel = i;
                if (sel < 0) begin
                    if (p0[0] == 1'b0) sel = p0[1] ? 1 : 0;
                    else               sel = p0[2] ? 3 : 2;
                end
                m_ent[sel] = u;
                m_val[sel] = 1'b1;
            end
            m_idx = 2'(sel);
            m_touch(2'(sel));
        end
    endfunction

    task automatic cyc(input bit rv, input logic [1:0] ri,
                       input bit uv, input logic [17:0] u);
        read_valid       = rv;
        read_index       = ri;
        update0_valid    = uv;
        update0_upper_PC = u;
        m_step(rv, ri, uv, u);
        @(posedge CLK);
        #1;
        chk("read_upper_PC", 32'(read_upper_PC), 32'(m_rd));
        chk("upd_index", 32'(update1_upper_PC_index), 32'(m_idx));
        read_valid    = 1'b0;
        update0_valid = 1'b0;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        #1;
        chk("rst_rd", 32'(read_upper_PC), 32'h0);
        chk("rst_idx", 32'(update1_upper_PC_index), 32'h0);
        m_reset();
        @(posedge CLK);
        #1;
        RST = 1'b0;
    endtask

    task automatic fill();
        for (int i = 0; i < 4; i++) begin
            cyc(0, 2'd0, 1, 18'(i + 1));
            chk("fill_idx", 32'(update1_upper_PC_index), 32'(i));
        end
    endtask

    logic [17:0] u;

    initial begin
        RST              = 1'b1;
        read_valid       = 1'b0;
        read_index       = '0;
        update0_valid    = 1'b0;
        update0_upper_PC = '0;
        m_reset();
        #2;
        do_reset();

        cyc(1, 2'd2, 0, 18'h0);
        chk("tp_rd_reset", 32'(read_upper_PC), 32'h0);
        chk("tp_idx_reset", 32'(update1_upper_PC_index), 32'h0);

        fill();
        cyc(1, 2'd1, 0, 18'h0);
        chk("tp_rd1", 32'(read_upper_PC), 32'h2);

        do_reset();
        fill();
        cyc(0, 2'd0, 1, 18'h3);
        chk("tp_hit3", 32'(update1_upper_PC_index), 32'h2);
        for (int i = 0; i < 4; i++) begin
            cyc(1, 2'(i), 0, 18'h0);
            chk("tp_unchanged", 32'(read_upper_PC), 32'(i + 1));
        end

        do_reset();
        fill();
        cyc(0, 2'd0, 1, 18'h5);
        chk("tp_victim0", 32'(update1_upper_PC_index), 32'h0);
        cyc(1, 2'd0, 0, 18'h0);
        chk("tp_rd5", 32'(read_upper_PC), 32'h5);
        cyc(0, 2'd0, 1, 18'h6);
        chk("tp_victim2", 32'(update1_upper_PC_index), 32'h2);

        do_reset();
        fill();
        cyc(1, 2'd0, 1, 18'h7);
        chk("tp_same_rd", 32'(read_upper_PC), 32'h1);
        chk("tp_same_idx", 32'(update1_upper_PC_index), 32'h0);
        cyc(1, 2'd0, 0, 18'h0);
        chk("tp_same_new", 32'(read_upper_PC), 32'h7);

        // Asynchronous reset mid-cycle, with requests held during reset
        cyc(1, 2'd3, 1, 18'h9);
        #2;
        RST = 1'b1;
        #1;
        chk("async_rd", 32'(read_upper_PC), 32'h0);
        chk("async_idx", 32'(update1_upper_PC_index), 32'h0);
        m_reset();
        read_valid       = 1'b1;
        read_index       = 2'd1;
        update0_valid    = 1'b1;
        update0_upper_PC = 18'h4;
        @(posedge CLK);
        #1;
        chk("hold_rd", 32'(read_upper_PC), 32'h0);
        chk("hold_idx", 32'(update1_upper_PC_index), 32'h0);
        read_valid    = 1'b0;
        update0_valid = 1'b0;
        RST           = 1'b0;
        cyc(0, 2'd0, 1, 18'h4);
        chk("post_rst_idx", 32'(update1_upper_PC_index), 32'h0);
        cyc(1, 2'd0, 0, 18'h0);
        chk("post_rst_rd", 32'(read_upper_PC), 32'h4);

        for (int n = 0; n < 500; n++) begin
            if ($urandom_range(0, 3) == 0) u = 18'($urandom);
            else                           u = 18'($urandom_range(1, 7));
            cyc(bit'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                bit'($urandom_range(0, 1)), u);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
